// File: rtl/bus_timer_responder_if.sv
// Shared tristate data/address bus seen by the timer target.
// The master drives ADDR/WE/OE; D is bidirectional and hit reports the window decode.
interface bus_timer_responder_if;
    logic [31:0] ADDR;
    wire  [63:0] D;
    logic        WE;
    logic        OE;
    logic        hit;

    modport master (
        output ADDR,
        output WE,
        output OE,
        inout  D,
        input  hit
    );

    modport slave (
        input  ADDR,
        input  WE,
        input  OE,
        inout  D,
        output hit
    );
endinterface

// File: rtl/bus_timer_responder.sv
// Memory-mapped 64-bit countdown timer on the shared tristate bus.
// Prescaled decrement, one-shot or auto-reload, level interrupt on expiry.
module bus_timer_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0C00,
    parameter logic [63:0] ID_VALUE  = 64'h0000_0000_544D_5231
) (
    input  logic                        clk,
    input  logic                        rst,
    bus_timer_responder_if.slave        bus,
    output logic                        irq
);

    localparam logic [2:0] OffCtrl   = 3'd0;
    localparam logic [2:0] OffLoad   = 3'd1;
    localparam logic [2:0] OffCount  = 3'd2;
    localparam logic [2:0] OffStatus = 3'd3;
    localparam logic [2:0] OffId     = 3'd4;

    logic        en_q, en_d;
    logic        auto_reload_q, auto_reload_d;
    logic        irq_en_q, irq_en_d;
    logic [7:0]  psc_q, psc_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic [63:0] load_q, load_d;
    logic [63:0] count_q, count_d;
    logic        expired_q, expired_d;

    logic        wr;
    logic        rd;
    logic        expire;
    logic [2:0]  offset;
    logic [63:0] rdata;

    assign bus.hit = (bus.ADDR[31:3] == BASE_ADDR[31:3]);
    assign offset  = bus.ADDR[2:0];
    assign wr      = bus.hit & bus.WE;
    assign rd      = bus.hit & bus.OE & ~bus.WE;

    always_comb begin
        en_d          = en_q;
        auto_reload_d = auto_reload_q;
        irq_en_d      = irq_en_q;
        psc_d         = psc_q;
        pcnt_d        = pcnt_q;
        load_d        = load_q;
        count_d       = count_q;
        expired_d     = expired_q;
        expire        = 1'b0;

        if (en_q) begin
            if (pcnt_q == psc_q) begin
                pcnt_d = '0;
                if (count_q != 64'd0) begin
                    count_d = count_q - 64'd1;
                end else begin
                    expire = 1'b1;
                    // Reload reads the current LOAD; a same-edge LOAD write lands afterwards.
                    if (auto_reload_q) begin
                        count_d = load_q;
                    end else begin
                        en_d = 1'b0;
                    end
                end
            end else begin
                pcnt_d = pcnt_q + 8'd1;
            end
        end else begin
            pcnt_d = '0;
        end

        // Bus writes override the counter's own updates on the same edge.
        if (wr) begin
            case (offset)
                OffCtrl: begin
                    en_d          = bus.D[0];
                    auto_reload_d = bus.D[1];
                    irq_en_d      = bus.D[2];
                    psc_d         = bus.D[15:8];
                    pcnt_d        = '0;
                end
                OffLoad:   load_d  = bus.D;
                OffCount:  count_d = bus.D;
                OffStatus: if (bus.D[0]) expired_d = 1'b0;
                default: ;
            endcase
        end

        // A fresh expiry beats a simultaneous write-1-to-clear.
        if (expire) begin
            expired_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q          <= 1'b0;
            auto_reload_q <= 1'b0;
            irq_en_q      <= 1'b0;
            psc_q         <= '0;
            pcnt_q        <= '0;
            load_q        <= '0;
            count_q       <= '0;
            expired_q     <= 1'b0;
        end else begin
            en_q          <= en_d;
            auto_reload_q <= auto_reload_d;
            irq_en_q      <= irq_en_d;
            psc_q         <= psc_d;
            pcnt_q        <= pcnt_d;
            load_q        <= load_d;
            count_q       <= count_d;
            expired_q     <= expired_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            OffCtrl:   rdata = {48'd0, psc_q, 5'd0, irq_en_q, auto_reload_q, en_q};
            OffLoad:   rdata = load_q;
            OffCount:  rdata = count_q;
            OffStatus: rdata = {63'd0, expired_q};
            OffId:     rdata = ID_VALUE;
            default:   rdata = '0;
        endcase
    end

    assign bus.D = rd ? rdata : 64'bz;
    assign irq   = expired_q & irq_en_q;

endmodule

// File: tb/tb_bus_timer_responder.sv
// Self-checking bench for bus_timer_responder: directed scenarios plus randomized
// bus traffic compared against a cycle-level behavioural model of the timer.
module tb_bus_timer_responder;

    localparam logic [31:0] Base = 32'h0000_0C00;
    localparam logic [63:0] Id   = 64'h0000_0000_544D_5231;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        irq;
    logic        drv_en = 1'b0;
    logic [63:0] drv_d  = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bus_timer_responder_if bus ();
    assign bus.D = drv_en ? drv_d : 64'bz;

    bus_timer_responder #(
        .BASE_ADDR (Base),
        .ID_VALUE  (Id)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .irq (irq)
    );

    // Behavioural model: registers as the software view, plus cycles left until the next tick.
    logic        m_en, m_ar, m_ie, m_exp;
    logic [7:0]  m_psc;
    logic [63:0] m_load, m_count;
    int          m_left;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0;
        m_psc = 0; m_load = 0; m_count = 0; m_left = 0;
    endtask

    function automatic logic [63:0] model_read(input logic [2:0] off);
        case (off)
            3'd0:    return {48'd0, m_psc, 5'd0, m_ie, m_ar, m_en};
            3'd1:    return m_load;
            3'd2:    return m_count;
            3'd3:    return {63'd0, m_exp};
            3'd4:    return Id;
            default: return 64'd0;
        endcase
    endfunction

    // One clock edge of timer behaviour, given whether a write to `off` happens on it.
    task automatic model_step(input bit w, input logic [2:0] off, input logic [63:0] data);
        bit          tick;
        bit          set_exp;
        logic [63:0] old_load;
        tick     = m_en && (m_left == 0);
        set_exp  = tick && (m_count == 0);
        old_load = m_load;
        if (m_en) m_left = tick ? int'(m_psc) : m_left - 1;
        if (tick) begin
            if (m_count != 0) m_count = m_count - 1;
            else if (m_ar) m_count = old_load;
            else m_en = 0;
        end
        if (w) begin
            case (off)
                3'd0: begin
                    m_en = data[0]; m_ar = data[1]; m_ie = data[2];
                    m_psc = data[15:8]; m_left = int'(data[15:8]);
                end
                3'd1: m_load  = data;
                3'd2: m_count = data;
                3'd3: if (data[0]) m_exp = 0;
                default: ;
            endcase
        end
        if (set_exp) m_exp = 1;
    endtask

    // One bus cycle: present signals after the falling edge, check combinational
    // outputs, let the rising edge happen, then check irq against the model.
    task automatic access(input logic [31:0] addr, input bit we, input bit oe,
                          input logic [63:0] data, input string tag);
        bit in_win;
        @(negedge clk);
        bus.ADDR = addr;
        bus.WE   = we;
        bus.OE   = oe;
        drv_en   = we;
        drv_d    = data;
        #1;
        in_win = (addr[31:3] == Base[31:3]);
        check({tag, ".hit"}, {63'd0, bus.hit}, {63'd0, in_win});
        if (we) begin
            check({tag, ".busw"}, bus.D, data);
        end else if (oe && in_win) begin
            check({tag, ".rd"}, bus.D, model_read(addr[2:0]));
        end else if (oe) begin
            check({tag, ".hiz"}, {63'd0, (bus.D === 64'd0) || (bus.D === 64'bz)}, 64'd1);
        end
        model_step(in_win && we, addr[2:0], data);
        @(posedge clk);
        #1;
        check({tag, ".irq"}, {63'd0, irq}, {63'd0, m_exp & m_ie});
    endtask

    task automatic wr(input logic [2:0] off, input logic [63:0] data, input string tag);
        access(Base | {29'd0, off}, 1'b1, 1'b0, data, tag);
    endtask

    task automatic rd(input logic [2:0] off, input string tag);
        access(Base | {29'd0, off}, 1'b0, 1'b1, 64'd0, tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) access(32'h0, 1'b0, 1'b0, 64'd0, "idle");
    endtask

    initial begin
        bus.ADDR = '0;
        bus.WE   = 1'b0;
        bus.OE   = 1'b0;
        model_reset();
        #12;
        check("rst.irq", {63'd0, irq}, 64'd0);
        rst = 1'b1;

        // Reset values and the unused window slots.
        for (int i = 0; i < 8; i++) rd(3'(i), "reset_rd");

        // Decode and tristate behaviour.
        access(32'h0000_0BF8, 1'b0, 1'b1, 64'd0, "dec_below");
        access(32'h0000_0C08, 1'b0, 1'b1, 64'd0, "dec_above");
        access(32'h0000_0C01, 1'b1, 1'b1, 64'hDEAD_BEEF_0123_4567, "we_over_oe");
        rd(3'd1, "load_cap");
        wr(3'd1, 64'd0, "load_clr");

        // One-shot: COUNT 3, en+irq_en, psc 0.
        wr(3'd2, 64'd3, "os_count");
        wr(3'd0, 64'h5, "os_ctrl");
        for (int i = 0; i < 5; i++) rd(3'd2, "os_cnt");
        rd(3'd0, "os_en_off");
        check("os_irq_set", {63'd0, irq}, 64'd1);
        wr(3'd3, 64'd1, "os_w1c");
        check("os_irq_clr", {63'd0, irq}, 64'd0);

        // Auto-reload with psc 1: watch COUNT and STATUS across several periods.
        wr(3'd1, 64'd2, "ar_load");
        wr(3'd2, 64'd2, "ar_count");
        wr(3'd0, 64'h0000_0107, "ar_ctrl");
        for (int i = 0; i < 14; i++) rd(3'd2, "ar_cnt");
        for (int i = 0; i < 6; i++) rd(3'd3, "ar_stat");
        wr(3'd0, 64'h0, "ar_stop");
        wr(3'd3, 64'd1, "ar_w1c");

        // W1C on the expiry edge: set wins.
        wr(3'd2, 64'd0, "c1_count");
        wr(3'd0, 64'h5, "c1_ctrl");
        wr(3'd3, 64'd1, "c1_w1c");
        rd(3'd3, "c1_stat");
        check("c1_irq_held", {63'd0, irq}, 64'd1);
        wr(3'd3, 64'd1, "c1_clr");

        // COUNT write on the reload edge wins; LOAD write on the reload edge is deferred.
        wr(3'd1, 64'd5, "c2_load");
        wr(3'd2, 64'd0, "c2_count");
        wr(3'd0, 64'h3, "c2_ctrl");
        wr(3'd2, 64'd100, "c2_wcount");
        rd(3'd2, "c2_cnt");
        wr(3'd2, 64'd0, "c3_count");
        idle(1);
        wr(3'd1, 64'd9, "c3_wload");
        rd(3'd2, "c3_cnt_oldload");
        rd(3'd1, "c3_load_new");

        // CTRL write on the one-shot expiry edge keeps en.
        wr(3'd0, 64'h0, "c4_stop");
        wr(3'd2, 64'd0, "c4_count");
        wr(3'd0, 64'h1, "c4_ctrl");
        wr(3'd0, 64'h1, "c4_wctrl");
        rd(3'd0, "c4_en_kept");

        // Async reset mid-count with irq asserted.
        wr(3'd0, 64'h0, "ar0");
        wr(3'd2, 64'd0, "ar0_count");
        wr(3'd0, 64'h5, "ar0_ctrl");
        idle(1);
        wr(3'd2, 64'd50, "ar0_c50");
        wr(3'd0, 64'h5, "ar0_run");
        idle(3);
        check("pre_rst_irq", {63'd0, irq}, 64'd1);
        @(negedge clk);
        bus.ADDR = Base | 32'd2;
        bus.OE   = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("mid_rst_irq", {63'd0, irq}, 64'd0);
        check("mid_rst_count", bus.D, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(4);
        rd(3'd2, "post_rst_cnt");
        rd(3'd0, "post_rst_ctrl");
        rd(3'd3, "post_rst_stat");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            int unsigned op = $urandom_range(0, 9);
            logic [2:0]  off = 3'($urandom_range(0, 7));
            logic [63:0] d;
            if (op < 4) begin
                rd(off, "rnd_rd");
            end else if (op == 4) begin
                access($urandom_range(0, 1) ? 32'h0000_0C08 : $urandom, 1'b0, 1'b1, 64'd0,
                       "rnd_out");
            end else if (op == 5) begin
                idle(1);
            end else begin
                d = {$urandom, $urandom};
                if (off == 3'd0) d[15:8] = 8'($urandom_range(0, 3));
                if (off == 3'd1 || off == 3'd2) d = 64'($urandom_range(0, 6));
                access(Base | {29'd0, off}, 1'b1, 1'($urandom_range(0, 1)), d, "rnd_wr");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_timer_responder.md
Name: bus_timer_responder

Overview:
Memory-mapped 64-bit countdown timer that sits as a target on the shared data bus (D) and address bus (ADDR) driven by the datapath. It decodes its address window, captures register writes from D when WE is high and drives read data onto D when OE is high. It raises a level interrupt when the count expires. It coexists with the RAM and ROM on the same tristate bus.

Parameters:
BASE_ADDR, 32'h0000_0C00, word address of register 0; must be 8-aligned (BASE_ADDR[2:0]=0)
ID_VALUE, 64'h0000_0000_544D_5231, constant returned by the ID register

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low
ADDR  input  32  address bus (word address)
D  inout  64  shared data bus; driven only during a selected read, high-Z otherwise
WE  input  1  bus write enable
OE  input  1  bus output enable
irq  output  1  level interrupt = STATUS.expired & CTRL.irq_en
hit  output  1  combinational: ADDR is inside this block's 8-word window

Behaviour:
- Window decode: hit = (ADDR[31:3] == BASE_ADDR[31:3]); offset = ADDR[2:0].
- Register map (offset):
  - 0 CTRL (R/W): bit0 en, bit1 auto_reload, bit2 irq_en, bits[15:8] psc; other bits read 0.
  - 1 LOAD (R/W, 64b).
  - 2 COUNT (R/W, 64b).
  - 3 STATUS: bit0 expired; write-1-to-clear; other bits read 0.
  - 4 ID (RO, ID_VALUE).
  - 5-7 read 0; writes to them are ignored.
- Write: at rising clk edge when hit & WE, the register at offset is updated from D. WE has priority over OE.
- Read: D = register value combinationally while hit & OE & ~WE, else 64'bz. Zero-cycle latency, so data is valid within the same cycle for the regfile to capture at the next rising edge.
- Reset (rst=0, asynchronous): CTRL=0, LOAD=0, COUNT=0, STATUS=0, prescaler counter=0. Outputs: irq=0, D=high-Z. Reset mid-operation aborts counting immediately.
- Prescaler: 8-bit pcnt, active while en=1.
  - tick when pcnt==psc; on tick pcnt<=0, else pcnt<=pcnt+1.
  - psc=0 gives a tick every cycle; psc=N gives a tick every N+1 cycles.
  - pcnt is held at 0 while en=0 and cleared on any CTRL write.
- Counter, on a tick with en=1:
  - COUNT!=0: COUNT<=COUNT-1.
  - COUNT==0: expired<=1. If auto_reload, COUNT<=LOAD and en stays 1; otherwise COUNT stays 0 and en<=0 (one-shot).
  - Expiry occurs on the tick that finds COUNT==0, so an expiry period is (LOAD+1)*(psc+1) cycles.
- Simultaneous events (same edge):
  - Bus write to COUNT vs decrement/reload: the write wins.
  - Bus write to CTRL vs one-shot auto-clear of en: the written value wins.
  - STATUS W1C vs new expiry: set wins, expired=1.
  - Bus write to LOAD vs reload: the reload uses the old LOAD; the new LOAD applies from the next edge.
- Wrap: COUNT never underflows. Writing COUNT=0 with en=1 expires on the next tick.
- irq is combinational from registered state and has no glitches from ADDR/D.

Test Plan:
- Reset/bus idle: rst=0 then 1, no access → irq=0, D=Z. Read CTRL/LOAD/COUNT/STATUS → 0. Read offset 4 → 64'h544D5231. Read offset 6 → 0.
- Decode/tristate: ADDR=32'h0BF8 or 32'h0C08 with OE=1 → hit=0, D=Z. ADDR=32'h0C01 with OE=1 and WE=1 → D=Z; LOAD captures the bus value.
- One-shot: LOAD unused, COUNT=3, CTRL=32'h5 (en, irq_en, psc=0) → COUNT reads 2,1,0 on successive cycles. The 4th cycle sets expired and irq=1; CTRL.en reads 0. Write STATUS=1 → irq=0.
- Auto-reload + prescaler: LOAD=2, COUNT=2, CTRL=32'h0000_0103 (psc=1) → expired sets every 6 cycles and COUNT returns to 2 after each expiry. Reading COUNT mid-period shows a value held for 2 cycles per step.
- Collisions: W1C STATUS on the expiry edge → expired stays 1. Write COUNT=100 on the reload edge → COUNT=100. Write CTRL=32'h1 on the one-shot expiry edge → en remains 1.
- Async reset mid-count: assert rst low between edges while COUNT=50 and en=1 → all registers clear immediately, irq=0, no further decrements after release until CTRL is rewritten.
